// File: rtl/fe65p2_seq_pkg.sv
// Shared types and default sizing for the injection/trigger sequencer.
package fe65p2_seq_pkg;

    localparam int unsigned CNT_WIDTH_DEF     = 16;
    localparam int unsigned DLY_WIDTH_DEF     = 8;
    localparam int unsigned DRAIN_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INJ_HI   = 3'd1,
        TRIG_DLY = 3'd2,
        TRIG_HI  = 3'd3,
        QUIET    = 3'd4,
        DRAIN    = 3'd5,
        FINISH   = 3'd6
    } seq_state_t;

    // Bits needed to hold a cycle count of n.
    function automatic int unsigned timer_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; stops at zero, load value may be forced to >= 1.
module seq_down_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             min_one,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] load_eff;

    // A duration of N cycles is held as N-1; zero-length loads without min_one are skipped by the caller.
    always_comb begin
        load_eff = load_val;
        if (min_one && (load_val == '0)) begin
            load_eff = WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_eff - WIDTH'(1);
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/inj_trig_sequencer.sv
// Autonomous injection/trigger scheduler: repeats INJ pulse, delayed TRIG pulse,
// quiet window and FIFO drain hold for a latched number of injections.
module inj_trig_sequencer
    import fe65p2_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int unsigned DLY_WIDTH     = DLY_WIDTH_DEF,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] CFG_REPEAT,
    input  logic [DLY_WIDTH-1:0] CFG_INJ_WIDTH,
    input  logic [DLY_WIDTH-1:0] CFG_TRIG_DELAY,
    input  logic [DLY_WIDTH-1:0] CFG_TRIG_WIDTH,
    input  logic [CNT_WIDTH-1:0] CFG_WAIT,
    input  logic                 FIFO_BUSY,
    output logic                 INJ,
    output logic                 TRIG,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] INJ_CNT,
    output logic                 TIMEOUT_ERR
);

    localparam int unsigned DRN_W = timer_width(DRAIN_TIMEOUT);

    seq_state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] rep_q, wait_q, inj_cnt, inj_cnt_inc;
    logic [DLY_WIDTH-1:0] injw_q, dly_q, trigw_q;
    logic                 inj_q, trig_q, busy_q, done_q, timeout_q;

    logic                 start_acc, cnt_inc, to_set;
    logic                 dur_load, dur_dec, dur_min1, dur_zero;
    logic [CNT_WIDTH-1:0] dur_val;
    logic                 drn_load, drn_dec, drn_zero;

    assign inj_cnt_inc = inj_cnt + CNT_WIDTH'(1);
    assign drn_dec     = (state == DRAIN);

    seq_down_counter #(.WIDTH(CNT_WIDTH)) u_dur_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (dur_load),
        .min_one  (dur_min1),
        .load_val (dur_val),
        .dec      (dur_dec),
        .zero_c   (dur_zero)
    );

    seq_down_counter #(.WIDTH(DRN_W)) u_drn_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (drn_load),
        .min_one  (1'b1),
        .load_val (DRN_W'(DRAIN_TIMEOUT)),
        .dec      (drn_dec),
        .zero_c   (drn_zero)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and timer control; ABORT overrides everything including a same-cycle START.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        cnt_inc   = 1'b0;
        to_set    = 1'b0;
        dur_load  = 1'b0;
        dur_dec   = 1'b0;
        dur_min1  = 1'b0;
        dur_val   = '0;
        drn_load  = 1'b0;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        start_acc = 1'b1;
                        if (CFG_REPEAT == '0) begin
                            state_nxt = FINISH;
                        end else begin
                            state_nxt = INJ_HI;
                            dur_load  = 1'b1;
                            dur_min1  = 1'b1;
                            dur_val   = CNT_WIDTH'(CFG_INJ_WIDTH);
                        end
                    end
                end
                INJ_HI: begin
                    if (dur_zero) begin
                        dur_load = 1'b1;
                        if (dly_q != '0) begin
                            state_nxt = TRIG_DLY;
                            dur_val   = CNT_WIDTH'(dly_q);
                        end else begin
                            state_nxt = TRIG_HI;
                            dur_min1  = 1'b1;
                            dur_val   = CNT_WIDTH'(trigw_q);
                        end
                    end else begin
                        dur_dec = 1'b1;
                    end
                end
                TRIG_DLY: begin
                    if (dur_zero) begin
                        state_nxt = TRIG_HI;
                        dur_load  = 1'b1;
                        dur_min1  = 1'b1;
                        dur_val   = CNT_WIDTH'(trigw_q);
                    end else begin
                        dur_dec = 1'b1;
                    end
                end
                TRIG_HI: begin
                    if (dur_zero) begin
                        if (wait_q != '0) begin
                            state_nxt = QUIET;
                            dur_load  = 1'b1;
                            dur_val   = wait_q;
                        end else begin
                            state_nxt = DRAIN;
                            drn_load  = 1'b1;
                        end
                    end else begin
                        dur_dec = 1'b1;
                    end
                end
                QUIET: begin
                    if (dur_zero) begin
                        state_nxt = DRAIN;
                        drn_load  = 1'b1;
                    end else begin
                        dur_dec = 1'b1;
                    end
                end
                DRAIN: begin
                    if (!FIFO_BUSY || drn_zero) begin
                        cnt_inc = 1'b1;
                        to_set  = FIFO_BUSY;
                        if (inj_cnt_inc == rep_q) begin
                            state_nxt = FINISH;
                        end else begin
                            state_nxt = INJ_HI;
                            dur_load  = 1'b1;
                            dur_min1  = 1'b1;
                            dur_val   = CNT_WIDTH'(injw_q);
                        end
                    end
                end
                FINISH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inj_q  <= 1'b0;
            trig_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inj_q  <= (state_nxt == INJ_HI);
            trig_q <= (state_nxt == TRIG_HI);
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == FINISH);
        end
    end

    // Run configuration, injection count and sticky drain-timeout flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rep_q     <= '0;
            wait_q    <= '0;
            injw_q    <= '0;
            dly_q     <= '0;
            trigw_q   <= '0;
            inj_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_acc) begin
                rep_q     <= CFG_REPEAT;
                wait_q    <= CFG_WAIT;
                injw_q    <= CFG_INJ_WIDTH;
                dly_q     <= CFG_TRIG_DELAY;
                trigw_q   <= CFG_TRIG_WIDTH;
                inj_cnt   <= '0;
                timeout_q <= 1'b0;
            end
            if (cnt_inc) begin
                inj_cnt <= inj_cnt_inc;
            end
            if (to_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign INJ         = inj_q;
    assign TRIG        = trig_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign INJ_CNT     = inj_cnt;
    assign TIMEOUT_ERR = timeout_q;

endmodule

// File: tb/tb_inj_trig_sequencer.sv
// Directed bench for inj_trig_sequencer; per-run waveforms are captured as bit traces
// where bit k holds the output value seen just before clock edge k (START sampled at edge 0).
module tb_inj_trig_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [15:0] CFG_REPEAT = '0;
    logic [7:0]  CFG_INJ_WIDTH = '0;
    logic [7:0]  CFG_TRIG_DELAY = '0;
    logic [7:0]  CFG_TRIG_WIDTH = '0;
    logic [15:0] CFG_WAIT = '0;
    logic        FIFO_BUSY = 1'b0;
    logic        INJ, TRIG, BUSY, DONE, TIMEOUT_ERR;
    logic [15:0] INJ_CNT;

    int n_chk  = 0;
    int n_fail = 0;
    int ovl    = 0;
    logic [127:0] inj_tr, trig_tr, done_tr, busy_tr, to_tr;

    inj_trig_sequencer #(.DRAIN_TIMEOUT(16)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .START          (START),
        .ABORT          (ABORT),
        .CFG_REPEAT     (CFG_REPEAT),
        .CFG_INJ_WIDTH  (CFG_INJ_WIDTH),
        .CFG_TRIG_DELAY (CFG_TRIG_DELAY),
        .CFG_TRIG_WIDTH (CFG_TRIG_WIDTH),
        .CFG_WAIT       (CFG_WAIT),
        .FIFO_BUSY      (FIFO_BUSY),
        .INJ            (INJ),
        .TRIG           (TRIG),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .INJ_CNT        (INJ_CNT),
        .TIMEOUT_ERR    (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mask(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[7'(i)] = 1'b1;
        return m;
    endfunction

    task automatic set_cfg(input logic [15:0] rep, input logic [7:0] w, input logic [7:0] d,
                           input logic [7:0] t, input logic [15:0] q);
        CFG_REPEAT     = rep;
        CFG_INJ_WIDTH  = w;
        CFG_TRIG_DELAY = d;
        CFG_TRIG_WIDTH = t;
        CFG_WAIT       = q;
    endtask

    // START at edge 0, then trace ncyc cycles; FIFO_BUSY/ABORT/START pulses given as edge numbers (-1 = none).
    task automatic run(input int ncyc, input int fb_lo, input int fb_hi, input int abort_at,
                       input int restart_at, input bit scramble);
        START     = 1'b1;
        ABORT     = (abort_at == 0);
        FIFO_BUSY = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        ABORT = 1'b0;
        if (scramble) set_cfg(16'd1, 8'd50, 8'd50, 8'd50, 16'd500);
        inj_tr = '0; trig_tr = '0; done_tr = '0; busy_tr = '0; to_tr = '0; ovl = 0;
        for (int e = 1; e <= ncyc; e++) begin
            inj_tr[7'(e)]  = INJ;
            trig_tr[7'(e)] = TRIG;
            done_tr[7'(e)] = DONE;
            busy_tr[7'(e)] = BUSY;
            to_tr[7'(e)]   = TIMEOUT_ERR;
            if (INJ && TRIG) ovl++;
            START     = (e == restart_at);
            ABORT     = (e == abort_at);
            FIFO_BUSY = (e >= fb_lo) && (e <= fb_hi);
            @(posedge CLK); #1;
        end
        START = 1'b0; ABORT = 1'b0; FIFO_BUSY = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_inj",  128'(INJ), '0);
        chk("rst_trig", 128'(TRIG), '0);
        chk("rst_busy", 128'(BUSY), '0);
        chk("rst_done", 128'(DONE), '0);
        chk("rst_cnt",  128'(INJ_CNT), '0);
        chk("rst_to",   128'(TIMEOUT_ERR), '0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Basic run, config scrambled after START and a START pulse mid-run must both be ignored.
        set_cfg(16'd3, 8'd4, 8'd2, 8'd3, 16'd10);
        run(70, -1, -1, -1, 30, 1'b1);
        chk("basic_inj",  inj_tr,  mask(1,4) | mask(21,24) | mask(41,44));
        chk("basic_trig", trig_tr, mask(7,9) | mask(27,29) | mask(47,49));
        chk("basic_done", done_tr, mask(61,61));
        chk("basic_busy", busy_tr, mask(1,61));
        chk("basic_to",   to_tr, '0);
        chk("basic_cnt",  128'(INJ_CNT), 128'(3));
        chk("basic_ovl",  128'(ovl), '0);

        // All duration fields zero.
        set_cfg(16'd1, 8'd0, 8'd0, 8'd0, 16'd0);
        run(10, -1, -1, -1, -1, 1'b0);
        chk("zero_inj",  inj_tr,  mask(1,1));
        chk("zero_trig", trig_tr, mask(2,2));
        chk("zero_done", done_tr, mask(4,4));
        chk("zero_busy", busy_tr, mask(1,4));
        chk("zero_cnt",  128'(INJ_CNT), 128'(1));

        // Zero repeat: immediate DONE, count cleared.
        set_cfg(16'd0, 8'd3, 8'd1, 8'd2, 16'd4);
        run(5, -1, -1, -1, -1, 1'b0);
        chk("rep0_inj",  inj_tr, '0);
        chk("rep0_trig", trig_tr, '0);
        chk("rep0_done", done_tr, mask(1,1));
        chk("rep0_busy", busy_tr, mask(1,1));
        chk("rep0_cnt",  128'(INJ_CNT), '0);

        // FIFO busy holds the first drain for 12 cycles, below the timeout.
        set_cfg(16'd2, 8'd2, 8'd1, 8'd1, 16'd3);
        run(35, 1, 19, -1, -1, 1'b0);
        chk("hold_inj",  inj_tr,  mask(1,2) | mask(21,22));
        chk("hold_trig", trig_tr, mask(4,4) | mask(24,24));
        chk("hold_done", done_tr, mask(29,29));
        chk("hold_busy", busy_tr, mask(1,29));
        chk("hold_to",   to_tr, '0);
        chk("hold_cnt",  128'(INJ_CNT), 128'(2));

        // FIFO stuck busy: each drain times out after 16 cycles, run still completes.
        set_cfg(16'd2, 8'd1, 8'd0, 8'd1, 16'd0);
        run(45, 1, 100, -1, -1, 1'b0);
        chk("tmo_inj",  inj_tr,  mask(1,1) | mask(19,19));
        chk("tmo_trig", trig_tr, mask(2,2) | mask(20,20));
        chk("tmo_done", done_tr, mask(37,37));
        chk("tmo_busy", busy_tr, mask(1,37));
        chk("tmo_to",   to_tr,   mask(19,45));
        chk("tmo_cnt",  128'(INJ_CNT), 128'(2));

        // Busy for 15 of 16 allowed drain cycles: no timeout, and START clears the sticky flag.
        set_cfg(16'd1, 8'd1, 8'd0, 8'd1, 16'd0);
        run(25, 1, 17, -1, -1, 1'b0);
        chk("edge_inj",  inj_tr,  mask(1,1));
        chk("edge_trig", trig_tr, mask(2,2));
        chk("edge_done", done_tr, mask(19,19));
        chk("edge_busy", busy_tr, mask(1,19));
        chk("edge_to",   to_tr, '0);
        chk("edge_cnt",  128'(INJ_CNT), 128'(1));

        // ABORT during TRIG_HI of the second injection.
        set_cfg(16'd3, 8'd2, 8'd1, 8'd4, 16'd2);
        run(30, -1, -1, 15, -1, 1'b0);
        chk("abort_inj",  inj_tr,  mask(1,2) | mask(11,12));
        chk("abort_trig", trig_tr, mask(4,7) | mask(14,15));
        chk("abort_done", done_tr, '0);
        chk("abort_busy", busy_tr, mask(1,15));
        chk("abort_cnt",  128'(INJ_CNT), 128'(1));
        chk("abort_ovl",  128'(ovl), '0);

        // START together with ABORT: no run, count untouched.
        set_cfg(16'd2, 8'd1, 8'd1, 8'd1, 16'd1);
        run(10, -1, -1, 0, -1, 1'b0);
        chk("sa_inj",  inj_tr, '0);
        chk("sa_busy", busy_tr, '0);
        chk("sa_done", done_tr, '0);
        chk("sa_cnt",  128'(INJ_CNT), 128'(1));

        // Asynchronous reset in the middle of INJ_HI.
        set_cfg(16'd1, 8'd8, 8'd0, 8'd1, 16'd0);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        chk("prerst_inj",  128'(INJ), 128'(1));
        chk("prerst_busy", 128'(BUSY), 128'(1));
        RST_N = 1'b0;
        #1;
        chk("arst_inj",  128'(INJ), '0);
        chk("arst_trig", 128'(TRIG), '0);
        chk("arst_busy", 128'(BUSY), '0);
        chk("arst_done", 128'(DONE), '0);
        chk("arst_cnt",  128'(INJ_CNT), '0);
        chk("arst_to",   128'(TIMEOUT_ERR), '0);
        #2;
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("postrst_busy", 128'(BUSY), '0);
        chk("postrst_inj",  128'(INJ), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
